irq_event_controller: RTL and testbench
=======================================

IRQ_EVENT_CONTROLLER -- requirements
Module: irq_event_controller

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources (legal range 1..16).
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 address  input  3  register word select.
REQ-005 chipselect  input  1  slave select.
REQ-006 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-007 writedata  input  16  write data.
REQ-008 readdata  output  16  registered read data.
REQ-009 irq_in  input  NUM_SRC  source requests (e.g. interval-timer irq), synchronous to clk.
REQ-010 irq  output  1  registered aggregate interrupt to the processor.

Function
REQ-011 Register map SHALL be: 0 PENDING (R, write-1-to-clear), 1 MASK (RW), 2 MODE (RW; bit=1 rising-edge, 0 level), 3 ACTIVE (R, PENDING&MASK), 4 VECTOR (R), 5 MISSED (see Configuration), 6-7 read 0.
REQ-012 Bits at index >= NUM_SRC SHALL read 0 and ignore writes.
REQ-013 Write strobe = chipselect && !write_n; reads need no strobe; readdata SHALL equal the mux value of the address presented in the previous cycle (1-cycle latency).
REQ-014 prev_in register SHALL hold irq_in of the prior cycle; rise[i] = irq_in[i] & !prev_in[i].
REQ-015 set[i] SHALL be rise[i] in edge mode, irq_in[i] in level mode.
REQ-016 Each cycle: PENDING <= (PENDING & ~clr) | set, clr = writedata bits on a write to address 0.
REQ-017 Simultaneous set and clear of one bit: set wins, bit stays 1.
REQ-018 Level-mode bit cleared while irq_in still high SHALL re-set on the next cycle.
REQ-019 MODE change SHALL not alter PENDING; new mode governs set from the following cycle.
REQ-020 VECTOR: bit15 = |ACTIVE; bits[3:0] = lowest index i with ACTIVE[i]=1, 0 when none.
REQ-021 irq SHALL be registered |(PENDING & MASK) computed from current-cycle register values, so irq asserts one cycle after PENDING/MASK allow it.
REQ-022 Writes to read-only addresses (3,4) SHALL have no effect.

Reset
REQ-023 On reset_n low, immediately: PENDING=0, MASK=0, MODE=0, prev_in=0, readdata=0, irq=0, MISSED=0.
REQ-024 Because prev_in resets to 0, an edge-mode source already high at reset release SHALL register as an edge on the first clock.
REQ-025 Reset mid-operation SHALL discard all pending events; no state survives.

Configuration
REQ-026 Macro IRQ_EVENT_CONTROLLER_MISSED_COUNT_EN defined: address 5 SHALL return a 16-bit counter incremented when any edge-mode rise[i] occurs while PENDING[i] already 1 and not being cleared that cycle; +1 per cycle max, saturating at 0xFFFF; any write to address 5 clears it (clear beats increment).
REQ-027 Macro undefined: counter logic absent; address 5 reads 0, writes ignored.

Verification
REQ-028 Reset, MODE=0x01, MASK=0x01, pulse irq_in[0] one cycle -> PENDING=0x0001, irq=1 one cycle after PENDING; write 0x0001 to addr 0 -> PENDING=0, irq=0 next cycle.
REQ-029 Level mode, irq_in[2] held high, MASK=0x04, write 0x0004 to addr 0 -> PENDING[2] reads 1 again; irq stays 1.
REQ-030 MASK=0x00, pulse irq_in[5] -> PENDING=0x0020, ACTIVE=0, irq=0; then MASK=0x20 -> irq=1 one cycle later.
REQ-031 PENDING=0x0048, MASK=0x00FF -> VECTOR reads 0x8003; MASK=0x0040 -> VECTOR=0x8006; MASK=0 -> VECTOR=0x0000.
REQ-032 Edge mode bit 1: rise on same cycle as W1C of bit 1 -> PENDING[1]=1 afterwards.
REQ-033 With IRQ_EVENT_CONTROLLER_MISSED_COUNT_EN: three edges on bit 0 without clearing -> MISSED=2; write addr 5 -> MISSED=0; without macro addr 5 reads 0.

Source files
------------

// File: rtl/irq_event_controller.sv
// irq_event_controller: memory-mapped interrupt aggregator with per-source
// edge/level capture, masking, priority vector and optional missed-edge counter.
//
// Ports:
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     register word select (0 PENDING, 1 MASK, 2 MODE, 3 ACTIVE,
//               4 VECTOR, 5 MISSED, 6-7 read zero)
//   chipselect  slave select; qualifies write_n
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, one cycle after address
//   irq_in      per-source requests, synchronous to clk
//   irq         registered aggregate interrupt
//
// Build option: define IRQ_EVENT_CONTROLLER_MISSED_COUNT_EN to include the
// saturating missed-edge counter at address 5; otherwise address 5 reads 0.

module irq_event_controller #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  localparam logic [2:0] AddrPending = 3'd0;
  localparam logic [2:0] AddrMask    = 3'd1;
  localparam logic [2:0] AddrMode    = 3'd2;
  localparam logic [2:0] AddrActive  = 3'd3;
  localparam logic [2:0] AddrVector  = 3'd4;
  localparam logic [2:0] AddrMissed  = 3'd5;

  function automatic logic [15:0] zext(input logic [NUM_SRC-1:0] v);
    logic [15:0] r;
    r = '0;
    r[NUM_SRC-1:0] = v;
    return r;
  endfunction

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] prev_in_q;
  logic [NUM_SRC-1:0] rise, set, clr, active;
  logic [15:0]        readdata_d, vector, missed_rd;
  logic               irq_d, wr_en;

  // Upper writedata bits are unused when NUM_SRC < 16.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en  = chipselect & ~write_n;
  assign rise   = irq_in & ~prev_in_q;
  assign set    = (mode_q & rise) | (~mode_q & irq_in);
  assign active = pending_q & mask_q;
  assign irq_d  = |active;

  always_comb begin
    clr    = '0;
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_en) begin
      if (address == AddrPending) clr    = writedata[NUM_SRC-1:0];
      if (address == AddrMask)    mask_d = writedata[NUM_SRC-1:0];
      if (address == AddrMode)    mode_d = writedata[NUM_SRC-1:0];
    end
    // Set is applied after clear so a coincident set wins.
    pending_d = (pending_q & ~clr) | set;
  end

  // Lowest active index wins: scan downward so the last hit is the lowest.
  always_comb begin
    vector     = '0;
    vector[15] = |active;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) vector[3:0] = 4'(i);
    end
  end

`ifdef IRQ_EVENT_CONTROLLER_MISSED_COUNT_EN
  logic [15:0] missed_q, missed_d;
  logic        miss;

  // A rise on an edge-mode source that is already pending and not being cleared.
  assign miss = |(mode_q & rise & pending_q & ~clr);

  always_comb begin
    missed_d = missed_q;
    if (wr_en && address == AddrMissed) begin
      missed_d = '0;
    end else if (miss && missed_q != 16'hFFFF) begin
      missed_d = missed_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) missed_q <= '0;
    else          missed_q <= missed_d;
  end

  assign missed_rd = missed_q;
`else
  assign missed_rd = '0;
`endif

  always_comb begin
    readdata_d = '0;
    case (address)
      AddrPending: readdata_d = zext(pending_q);
      AddrMask:    readdata_d = zext(mask_q);
      AddrMode:    readdata_d = zext(mode_q);
      AddrActive:  readdata_d = zext(active);
      AddrVector:  readdata_d = vector;
      AddrMissed:  readdata_d = missed_rd;
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      prev_in_q <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      prev_in_q <= irq_in;
      readdata  <= readdata_d;
      irq       <= irq_d;
    end
  end

endmodule

// File: tb/tb_irq_event_controller.sv
// Self-checking bench for irq_event_controller (NUM_SRC = 8).
// Inputs are driven and outputs sampled on the falling edge.

module tb_irq_event_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[12];

`ifdef IRQ_EVENT_CONTROLLER_MISSED_COUNT_EN
  localparam logic [15:0] ExpMissed2 = 16'd2;
  localparam logic [15:0] ExpMissed1 = 16'd1;
`else
  localparam logic [15:0] ExpMissed2 = 16'd0;
  localparam logic [15:0] ExpMissed1 = 16'd0;
`endif

  irq_event_controller #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_irq(input logic exp, input string name);
    check(name, {15'd0, irq}, {15'd0, exp});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Expected value reflects register state at issue time; readdata lands a cycle later.
  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    sb_t e;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    sb_q.push_back('{exp: exp, name: name});
    @(negedge clk);
    chipselect = 1'b0;
    e = sb_q.pop_front();
    check(e.name, readdata, e.exp);
  endtask

  initial begin
    tbl[0]  = '{addr: 3'd1, wdata: 16'hFFFF, exp: 16'h00FF};
    tbl[1]  = '{addr: 3'd1, wdata: 16'h00A5, exp: 16'h00A5};
    tbl[2]  = '{addr: 3'd2, wdata: 16'h1234, exp: 16'h0034};
    tbl[3]  = '{addr: 3'd2, wdata: 16'hFFFF, exp: 16'h00FF};
    tbl[4]  = '{addr: 3'd0, wdata: 16'hFFFF, exp: 16'h0000};
    tbl[5]  = '{addr: 3'd3, wdata: 16'hFFFF, exp: 16'h0000};
    tbl[6]  = '{addr: 3'd4, wdata: 16'hFFFF, exp: 16'h0000};
    tbl[7]  = '{addr: 3'd5, wdata: 16'hFFFF, exp: 16'h0000};
    tbl[8]  = '{addr: 3'd6, wdata: 16'hFFFF, exp: 16'h0000};
    tbl[9]  = '{addr: 3'd7, wdata: 16'hFFFF, exp: 16'h0000};
    tbl[10] = '{addr: 3'd1, wdata: 16'h0000, exp: 16'h0000};
    tbl[11] = '{addr: 3'd2, wdata: 16'h0000, exp: 16'h0000};

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    irq_in     = '0;
    #3;
    check("rst_readdata", readdata, 16'h0000);
    chk_irq(1'b0, "rst_irq");
    tick(2);
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, $sformatf("rst_reg%0d", a));

    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Edge capture, irq lag, write-1-to-clear.
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    tick(1);
    irq_in[0] = 1'b0;
    chk_irq(1'b0, "a_irq_lag");
    rd(3'd0, 16'h0001, "a_pending");
    chk_irq(1'b1, "a_irq_set");
    wr(3'd0, 16'h0001);
    chk_irq(1'b1, "a_irq_hold");
    tick(1);
    chk_irq(1'b0, "a_irq_clr");
    rd(3'd0, 16'h0000, "a_pending_clr");

    // Level source re-sets after clear; mode change keeps pending.
    irq_in[2] = 1'b1;
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0004);
    tick(1);
    chk_irq(1'b1, "b_irq");
    wr(3'd0, 16'h0004);
    rd(3'd0, 16'h0004, "b_pending_reset");
    chk_irq(1'b1, "b_irq_stays");
    wr(3'd2, 16'h0004);
    rd(3'd0, 16'h0004, "b_mode_keeps");
    wr(3'd0, 16'h0004);
    rd(3'd0, 16'h0000, "b_edge_no_reset");
    irq_in[2] = 1'b0;
    wr(3'd2, 16'h0000);
    tick(1);
    chk_irq(1'b0, "b_irq_off");

    // Masked pending, then unmask.
    wr(3'd1, 16'h0000);
    irq_in[5] = 1'b1;
    tick(1);
    irq_in[5] = 1'b0;
    rd(3'd0, 16'h0020, "c_pending");
    rd(3'd3, 16'h0000, "c_active");
    chk_irq(1'b0, "c_irq_masked");
    wr(3'd1, 16'h0020);
    chk_irq(1'b0, "c_irq_lag");
    tick(1);
    chk_irq(1'b1, "c_irq");
    wr(3'd0, 16'h0020);

    // Priority vector.
    irq_in = 8'h48;
    tick(1);
    irq_in = 8'h00;
    wr(3'd1, 16'h00FF);
    rd(3'd3, 16'h0048, "d_active");
    rd(3'd4, 16'h8003, "d_vec_ff");
    wr(3'd1, 16'h0040);
    rd(3'd4, 16'h8006, "d_vec_40");
    wr(3'd1, 16'h0000);
    rd(3'd4, 16'h0000, "d_vec_none");
    wr(3'd0, 16'h0048);
    rd(3'd0, 16'h0000, "d_pending_clr");

    // Edge coincident with clear: set wins.
    wr(3'd2, 16'h0002);
    irq_in[1] = 1'b1;
    tick(1);
    irq_in[1] = 1'b0;
    tick(1);
    rd(3'd0, 16'h0002, "e_pending");
    irq_in[1] = 1'b1;
    wr(3'd0, 16'h0002);
    rd(3'd0, 16'h0002, "e_set_wins");
    irq_in[1] = 1'b0;
    wr(3'd0, 16'h0002);
    rd(3'd0, 16'h0000, "e_clr");

    // Missed-edge counter.
    wr(3'd5, 16'h0000);
    wr(3'd2, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      irq_in[0] = 1'b1;
      tick(1);
      irq_in[0] = 1'b0;
      tick(1);
    end
    rd(3'd5, ExpMissed2, "f_missed");
    irq_in[0] = 1'b1;
    wr(3'd5, 16'h0000);
    irq_in[0] = 1'b0;
    rd(3'd5, 16'h0000, "f_clr_beats_inc");
    irq_in[0] = 1'b1;
    tick(1);
    irq_in[0] = 1'b0;
    rd(3'd5, ExpMissed1, "f_missed_one");
    rd(3'd0, 16'h0001, "f_pending");

    // Reset mid-operation.
    wr(3'd1, 16'h0001);
    tick(1);
    chk_irq(1'b1, "g_irq_pre");
    rd(3'd1, 16'h0001, "g_mask_pre");
    #2;
    reset_n = 1'b0;
    #1;
    check("g_rst_readdata", readdata, 16'h0000);
    chk_irq(1'b0, "g_rst_irq");
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd0, 16'h0000, "g_pending");
    rd(3'd1, 16'h0000, "g_mask");
    rd(3'd2, 16'h0000, "g_mode");
    rd(3'd5, 16'h0000, "g_missed");
    chk_irq(1'b0, "g_irq_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
